i2c_master_ctrl: RTL and testbench
==================================

# i2c_master_ctrl

I2C master sequencer that sits directly behind the UART command receiver. It consumes the decoded command fields and the one-cycle `i2c_enable` strobe, then drives one complete I2C transaction: a 16-bit register write, or a 16-bit register read using a repeated start. It reports completion, slave NACK and read data. Single master only: no arbitration and no clock stretching.

## Interface
- `CLK_FREQ`, 100000000, system clock frequency in Hz.
- `I2C_FREQ`, 100000, SCL frequency in Hz. `QCNT = CLK_FREQ/(4*I2C_FREQ)` clocks per quarter-bit; must be ≥1.
- `clk` in 1 — system clock, single clock domain.
- `rst_n` in 1 — asynchronous, active-low reset.
- `i2c_enable` in 1 — one-cycle command strobe.
- `device_addr` in 7 — 7-bit slave address.
- `rw` in 1 — 0 = write, 1 = read.
- `reg_addr` in 8 — slave register address.
- `i2c_data` in 16 — write payload, MSB byte sent first.
- `sda_i` in 1 — SDA pad input (externally synchronised).
- `scl` out 1 — SCL, push-pull.
- `sda_oe` out 1 — 1 pulls SDA low, 0 releases SDA (pull-up high).
- `busy` out 1 — a transaction is in progress.
- `done` out 1 — one-cycle pulse at the end of a transaction.
- `ack_err` out 1 — the last transaction saw a NACK or was rejected; valid from `done` until the next accepted command.
- `rd_data` out 16 — read result, updated only by a successful read.

## Operation
- Reset values: `scl`=1, `sda_oe`=0, `busy`=0, `done`=0, `ack_err`=0, `rd_data`=0, state IDLE. Reset acts immediately, including mid-transfer.
- In IDLE, `i2c_enable`=1 latches `device_addr`, `rw`, `reg_addr` and `i2c_data` into shadow registers and moves to START. `i2c_enable` while `busy` is ignored.
- Bit slot: 4 quarters q0–q3, each `QCNT` clocks.
  - Data bit: SDA set at q0 entry; `scl` low in q0–q1, high in q2–q3; `sda_i` sampled on the last clock of q2.
- START slot: SDA released and `scl` high in q0–q1; SDA pulled low at q2; `scl` low at q3.
- RSTART slot: `scl` low with SDA released in q0; `scl` high in q1; SDA low at q2; `scl` low at q3.
- STOP slot: `scl` low with SDA low in q0; `scl` high at q1; SDA released at q2; q3 stays idle-high.
- States:
  - IDLE, START, TX_BYTE (8 bits, MSB first), RX_ACK (SDA released), RX_BYTE (SDA released, shift `sda_i` in MSB first), TX_ACK, RSTART, STOP.
  - A byte index counter, 0–3, selects the next byte.
- Write sequence: START, {dev,0}, ACK, reg_addr, ACK, data[15:8], ACK, data[7:0], ACK, STOP.
- Read sequence: START, {dev,0}, ACK, reg_addr, ACK, RSTART, {dev,1}, ACK, RX byte + master ACK (SDA low), RX byte + master NACK (SDA released), STOP.
  - `rd_data` = {byte1, byte2}, loaded on the last clock of STOP.
- Sampled ACK bit = 1 (NACK) in any RX_ACK: abandon the remaining bytes, go to STOP, set `ack_err`=1, leave `rd_data` unchanged.
- On the last clock of STOP: `done`=1 for one cycle, and `busy` drops in the same cycle. Return to IDLE.

## Timing
- `busy` rises 1 clock after an accepted `i2c_enable`.
- The START slot begins on that same clock.
- Write with all ACKs: 38 bit slots, i.e. `152*QCNT` clocks from `busy` rise to `done`.
- Read with all ACKs: 48 bit slots, i.e. `192*QCNT` clocks.
- NACK at the first address byte: 11 slots (START + 9 + STOP).
- A new `i2c_enable` is accepted in the clock after `done`.

## Configuration
- `I2C_MASTER_READ_EN` defined: read transactions are supported as described above.
- `I2C_MASTER_READ_EN` undefined:
  - RSTART, RX_BYTE and TX_ACK logic are compiled out.
  - A command with `rw`=1 causes no bus activity: `busy` is high for exactly 1 clock, then `done`=1 with `ack_err`=1, and `rd_data` stays 0.
  - Write behaviour is unchanged.

## Test plan
All scenarios use `CLK_FREQ`=400 and `I2C_FREQ`=100, so `QCNT`=1; the slave model ACKs unless stated otherwise.
- Write: dev 0x50, rw 0, reg 0x12, data 0xABCD → SDA bytes 0xA0, 0x12, 0xAB, 0xCD; `done` 152 clocks after `busy` rise; `ack_err`=0.
- Read (macro defined): dev 0x50, reg 0x34, slave returns 0x5A then 0xC3 → bytes 0xA0, 0x34, RSTART, 0xA1; master ACK then NACK; `rd_data`=0x5AC3 at `done`; 192 clocks.
- Slave NACKs the reg byte → STOP follows immediately; `done` with `ack_err`=1; `rd_data` unchanged.
- Second `i2c_enable` pulse mid-write with different fields → ignored; bus bytes match the first command only.
- `rst_n` low during the data[15:8] byte → `scl`=1, `sda_oe`=0, `busy`=0 asynchronously; after release, a fresh write completes normally.
- Macro undefined, rw=1 → no SCL edges; `done` pulse with `ack_err`=1 two clocks after the strobe.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C sequencer for 16-bit register write/read.
// Optional feature macro: I2C_MASTER_READ_EN enables read transactions (repeated
//   start, two received bytes). Without it, read commands are rejected with
//   ack_err and no bus activity.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   i2c_enable          one-cycle command strobe (ignored while busy)
//   device_addr, rw,
//   reg_addr, i2c_data  command fields, latched on an accepted strobe
//   sda_i               SDA pad input (already synchronised)
//   scl, sda_oe         push-pull SCL, SDA pull-down enable
//   busy, done          transaction in progress, one-cycle completion pulse
//   ack_err, rd_data    NACK/reject status, last successful read result
module i2c_master_ctrl #(
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned I2C_FREQ = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i2c_enable,
   input  logic [6:0]  device_addr,
   input  logic        rw,
   input  logic [7:0]  reg_addr,
   input  logic [15:0] i2c_data,
   input  logic        sda_i,
   output logic        scl,
   output logic        sda_oe,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic [15:0] rd_data
);

   localparam int unsigned QCNT  = CLK_FREQ / (4 * I2C_FREQ);
   localparam int unsigned CW    = (QCNT > 1) ? $clog2(QCNT) : 1;
   localparam logic [CW-1:0] QLAST = CW'(QCNT - 1);

`ifdef I2C_MASTER_READ_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RX_BYTE, S_TX_ACK, S_RSTART, S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_STOP, S_REJECT
   } state_t;
`endif

   state_t         state_q, state_d;
   logic [1:0]     q_q, q_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [1:0]     idx_q, idx_d;
   logic [7:0]     sh_q, sh_d;
   logic           nack_q, nack_d;
   logic [6:0]     dev_q, dev_d;
   logic [7:0]     reg_q, reg_d;
   logic [15:0]    data_q, data_d;
   logic           scl_q, scl_d;
   logic           sda_oe_q, sda_oe_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           ack_err_q, ack_err_d;
   logic [15:0]    rd_data_q, rd_data_d;
`ifdef I2C_MASTER_READ_EN
   logic           rw_q, rw_d;
   logic [7:0]     rx_hi_q, rx_hi_d;
`endif

   logic tick;
   logic slot_end;

   // Write-direction byte selected by the byte index.
   function automatic logic [7:0] pick_byte(input logic [1:0]  i,
                                            input logic [6:0]  d,
                                            input logic [7:0]  r,
                                            input logic [15:0] w);
      logic [7:0] b;
      unique case (i)
         2'd0:    b = {d, 1'b0};
         2'd1:    b = r;
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         q_q       <= '0;
         cnt_q     <= '0;
         bit_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
         nack_q    <= 1'b0;
         dev_q     <= '0;
         reg_q     <= '0;
         data_q    <= '0;
         scl_q     <= 1'b1;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         rd_data_q <= '0;
`ifdef I2C_MASTER_READ_EN
         rw_q      <= 1'b0;
         rx_hi_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
         nack_q    <= nack_d;
         dev_q     <= dev_d;
         reg_q     <= reg_d;
         data_q    <= data_d;
         scl_q     <= scl_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         rd_data_q <= rd_data_d;
`ifdef I2C_MASTER_READ_EN
         rw_q      <= rw_d;
         rx_hi_q   <= rx_hi_d;
`endif
      end
   end

   assign tick     = (cnt_q == QLAST);
   assign slot_end = tick && (q_q == 2'd3);

   // Next-state, datapath and bus-drive logic. Bus outputs are derived from the
   // next state so the registered pins line up with the state register.
   always_comb begin
      state_d   = state_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      idx_d     = idx_q;
      sh_d      = sh_q;
      nack_d    = nack_q;
      dev_d     = dev_q;
      reg_d     = reg_q;
      data_d    = data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
      rd_data_d = rd_data_q;
      scl_d     = 1'b1;
      sda_oe_d  = 1'b0;
`ifdef I2C_MASTER_READ_EN
      rw_d      = rw_q;
      rx_hi_d   = rx_hi_q;
`endif

      // Quarter-bit timebase runs whenever a transaction is active.
      if (state_q != S_IDLE) begin
         if (tick) begin
            cnt_d = '0;
            q_d   = q_q + 2'd1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (i2c_enable) begin
               dev_d     = device_addr;
               reg_d     = reg_addr;
               data_d    = i2c_data;
               ack_err_d = 1'b0;
               nack_d    = 1'b0;
               busy_d    = 1'b1;
               q_d       = '0;
               cnt_d     = '0;
               idx_d     = '0;
               bit_d     = '0;
               state_d   = S_START;
`ifdef I2C_MASTER_READ_EN
               rw_d      = rw;
`else
               if (rw) state_d = S_REJECT;
`endif
            end
         end
         S_START: begin
            if (slot_end) begin
               state_d = S_TX_BYTE;
               idx_d   = 2'd0;
               bit_d   = '0;
               sh_d    = pick_byte(2'd0, dev_q, reg_q, data_q);
            end
         end
         S_TX_BYTE: begin
            if (slot_end) begin
               if (bit_q == 3'd7) begin
                  state_d = S_RX_ACK;
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = {sh_q[6:0], 1'b0};
               end
            end
         end
         S_RX_ACK: begin
            if (tick && (q_q == 2'd2)) nack_d = sda_i;
            if (slot_end) begin
               bit_d = '0;
               if (nack_q) begin
                  state_d = S_STOP;
`ifdef I2C_MASTER_READ_EN
               end else if (rw_q && (idx_q == 2'd1)) begin
                  state_d = S_RSTART;
               end else if (rw_q && (idx_q == 2'd2)) begin
                  // Address-read acknowledged: first received byte uses index 3.
                  state_d = S_RX_BYTE;
                  idx_d   = 2'd3;
`endif
               end else if (idx_q == 2'd3) begin
                  state_d = S_STOP;
               end else begin
                  state_d = S_TX_BYTE;
                  idx_d   = idx_q + 2'd1;
                  sh_d    = pick_byte(idx_q + 2'd1, dev_q, reg_q, data_q);
               end
            end
         end
`ifdef I2C_MASTER_READ_EN
         S_RSTART: begin
            if (slot_end) begin
               state_d = S_TX_BYTE;
               idx_d   = 2'd2;
               bit_d   = '0;
               sh_d    = {dev_q, 1'b1};
            end
         end
         S_RX_BYTE: begin
            if (tick && (q_q == 2'd2)) sh_d = {sh_q[6:0], sda_i};
            if (slot_end) begin
               if (bit_q == 3'd7) begin
                  state_d = S_TX_ACK;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_TX_ACK: begin
            // Index 3 marks the first received byte (ACK); index 0 the last (NACK).
            if (slot_end) begin
               if (idx_q == 2'd3) begin
                  rx_hi_d = sh_q;
                  idx_d   = 2'd0;
                  state_d = S_RX_BYTE;
               end else begin
                  state_d = S_STOP;
               end
            end
         end
`else
         S_REJECT: begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            ack_err_d = 1'b1;
         end
`endif
         S_STOP: begin
            if (slot_end) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               ack_err_d = nack_q;
`ifdef I2C_MASTER_READ_EN
               if (rw_q && !nack_q) rd_data_d = {rx_hi_q, sh_q};
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Pin levels for the quarter being entered.
      unique case (state_d)
         S_START: begin
            scl_d    = (q_d != 2'd3);
            sda_oe_d = q_d[1];
         end
         S_TX_BYTE: begin
            scl_d    = q_d[1];
            sda_oe_d = ~sh_d[7];
         end
         S_RX_ACK: scl_d = q_d[1];
`ifdef I2C_MASTER_READ_EN
         S_RX_BYTE: scl_d = q_d[1];
         S_TX_ACK: begin
            scl_d    = q_d[1];
            sda_oe_d = (idx_d == 2'd3);
         end
         S_RSTART: begin
            scl_d    = (q_d == 2'd1) || (q_d == 2'd2);
            sda_oe_d = q_d[1];
         end
`endif
         S_STOP: begin
            scl_d    = (q_d != 2'd0);
            sda_oe_d = ~q_d[1];
         end
         default: begin
            scl_d    = 1'b1;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   assign scl     = scl_q;
   assign sda_oe  = sda_oe_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: open-drain slave model, bus-token scoreboard and
// completion scoreboard fed by a transaction-level reference model.
module tb_i2c_master_ctrl;

   localparam int T_START = 1000;
   localparam int T_RS    = 1001;
   localparam int T_STOP  = 1002;
   localparam int BOUND   = 3000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i2c_enable = 1'b0;
   logic [6:0]  device_addr = '0;
   logic        rw = 1'b0;
   logic [7:0]  reg_addr = '0;
   logic [15:0] i2c_data = '0;
   logic        sda_i;
   logic        scl, sda_oe, busy, done, ack_err;
   logic [15:0] rd_data;
   logic        slv_pull = 1'b0;

   assign sda_i = ~(sda_oe | slv_pull);

   i2c_master_ctrl #(.CLK_FREQ(400), .I2C_FREQ(100)) dut (
      .clk(clk), .rst_n(rst_n), .i2c_enable(i2c_enable), .device_addr(device_addr),
      .rw(rw), .reg_addr(reg_addr), .i2c_data(i2c_data), .sda_i(sda_i),
      .scl(scl), .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err),
      .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   typedef struct { logic ae; logic [15:0] rd; int lat; int rises; } exp_t;
   exp_t exp_q[$];
   int   bus_q[$];

   int          total = 0, bad = 0, done_cnt = 0;
   longint      cyc = 0;
   logic [7:0]  slv_rd [2];
   int          nack_at = -1;
   bit          mon_en = 1'b0;
   logic [15:0] exp_rd = '0;

   // slave model state
   int          bitpos = 0, seg_bytes = 0, rx_cnt = 0;
   bit          in_txn = 1'b0, rd_seg = 1'b0, mack_nack = 1'b0;
   logic [8:0]  shreg = '0;
   logic        scl_p = 1'b1, sda_p = 1'b1, line;

   // completion monitor state
   logic        busy_p = 1'b0, scl_p2 = 1'b1;
   longint      t0 = 0;
   int          rises = 0;
   exp_t        e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name, input string what);
      total++;
      bad++;
      $display("FAIL %s %s", name, what);
   endtask

   task automatic push_tok(input int t);
      if (bus_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL bus_extra actual=%0h required=none", t);
      end else begin
         chk("bus_token", longint'(t), longint'(bus_q.pop_front()));
      end
   endtask

   // Reference model: expected bus tokens ({byte, ack}) and completion result.
   task automatic model(input logic [6:0] d, input logic r, input logic [7:0] ra,
                        input logic [15:0] wd, input int nk);
      logic [7:0] tx[$];
      int   slots, nr;
      logic ae;
      slots = 1; nr = 0; ae = 1'b0;
`ifndef I2C_MASTER_READ_EN
      if (r) begin
         exp_q.push_back('{1'b1, exp_rd, 1, 0});
         return;
      end
`endif
      if (r) tx = '{{d, 1'b0}, ra};
      else   tx = '{{d, 1'b0}, ra, wd[15:8], wd[7:0]};
      bus_q.push_back(T_START);
      foreach (tx[k]) begin
         if (!ae) begin
            bus_q.push_back(int'({tx[k], logic'(k == nk)}));
            slots += 9; nr += 9;
            if (k == nk) ae = 1'b1;
         end
      end
      if (r && !ae) begin
         bus_q.push_back(T_RS);
         slots += 1; nr += 1;
         bus_q.push_back(int'({d, 1'b1, logic'(nk == 2)}));
         slots += 9; nr += 9;
         if (nk == 2) ae = 1'b1;
         if (!ae) begin
            bus_q.push_back(int'({slv_rd[0], 1'b0}));
            bus_q.push_back(int'({slv_rd[1], 1'b1}));
            slots += 18; nr += 18;
            exp_rd = {slv_rd[0], slv_rd[1]};
         end
      end
      bus_q.push_back(T_STOP);
      slots += 1; nr += 1;
      exp_q.push_back('{ae, exp_rd, slots * 4, nr});
   endtask

   // Slave: decodes START/RSTART/STOP and bytes, ACKs unless told to NACK,
   // returns slv_rd bytes in a read segment.
   initial forever begin
      @(negedge clk);
      line = ~(sda_oe | slv_pull);
      if (!mon_en || !rst_n) begin
         bitpos = 0; seg_bytes = 0; rx_cnt = 0;
         in_txn = 1'b0; rd_seg = 1'b0; mack_nack = 1'b0; slv_pull = 1'b0;
      end else if (scl && scl_p && sda_p && !line) begin
         push_tok(in_txn ? T_RS : T_START);
         if (!in_txn) rx_cnt = 0;
         in_txn = 1'b1; bitpos = 0; seg_bytes = 0; rd_seg = 1'b0; mack_nack = 1'b0;
      end else if (scl && scl_p && !sda_p && line) begin
         push_tok(T_STOP);
         in_txn = 1'b0; bitpos = 0;
      end else if (scl && !scl_p) begin
         shreg = {shreg[7:0], line};
         bitpos++;
         if (bitpos == 9) begin
            push_tok(int'(shreg));
            if (rd_seg && seg_bytes >= 1) mack_nack = shreg[0];
            else rx_cnt++;
            if (seg_bytes == 0) rd_seg = shreg[1];
            seg_bytes++;
            bitpos = 0;
         end
      end else if (!scl && scl_p) begin
         if (bitpos == 8)
            slv_pull = (rd_seg && seg_bytes >= 1) ? 1'b0 : (rx_cnt != nack_at);
         else if (rd_seg && !mack_nack && seg_bytes >= 1 && seg_bytes <= 2)
            slv_pull = ~slv_rd[seg_bytes-1][7-bitpos];
         else
            slv_pull = 1'b0;
      end
      scl_p = scl;
      sda_p = ~(sda_oe | slv_pull);
   end

   // Completion monitor: pops the expected result on every done pulse.
   initial forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
         busy_p = 1'b0;
         scl_p2 = scl;
      end else begin
         if (scl && !scl_p2) rises++;
         if (busy && !busy_p) begin
            t0 = cyc;
            rises = 0;
         end
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               fail("done_extra", "unexpected done pulse");
            end else begin
               e = exp_q.pop_front();
               chk("ack_err", longint'(ack_err), longint'(e.ae));
               chk("rd_data", longint'(rd_data), longint'(e.rd));
               chk("latency", cyc - t0, longint'(e.lat));
               chk("scl_rises", longint'(rises), longint'(e.rises));
               chk("busy_at_done", longint'(busy), 0);
            end
         end
         busy_p = busy;
         scl_p2 = scl;
      end
   end

   task automatic issue(input logic [6:0] d, input logic r, input logic [7:0] ra,
                        input logic [15:0] wd, input int nk, input bit stray,
                        input logic [7:0] b0, input logic [7:0] b1);
      int n, start;
      n = 0;
      while (busy && n < BOUND) begin @(negedge clk); n++; end
      slv_rd[0] = b0;
      slv_rd[1] = b1;
      nack_at = nk;
      model(d, r, ra, wd, nk);
      start = done_cnt;
      device_addr = d; rw = r; reg_addr = ra; i2c_data = wd;
      i2c_enable = 1'b1;
      @(negedge clk);
      i2c_enable = 1'b0;
      if (stray) begin
         repeat (int'($urandom_range(5, 60))) @(negedge clk);
         if (busy) begin
            device_addr = 7'($urandom); rw = 1'($urandom);
            reg_addr = 8'($urandom); i2c_data = 16'($urandom);
            i2c_enable = 1'b1;
            @(negedge clk);
            i2c_enable = 1'b0;
         end
      end
      n = 0;
      while (done_cnt == start && n < BOUND) begin @(negedge clk); n++; end
      if (done_cnt == start) fail("done_timeout", "no done within bound");
      @(negedge clk);
   endtask

   initial begin
      int n;
      logic r;
      int nk;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_scl", longint'(scl), 1);
      chk("rst_sda_oe", longint'(sda_oe), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_ack_err", longint'(ack_err), 0);
      chk("rst_rd_data", longint'(rd_data), 0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      issue(7'h50, 1'b0, 8'h12, 16'hABCD, -1, 1'b0, 8'h00, 8'h00);
      issue(7'h50, 1'b1, 8'h34, 16'h0000, -1, 1'b0, 8'h5A, 8'hC3);
      issue(7'h50, 1'b0, 8'h12, 16'h1357, 1, 1'b0, 8'h00, 8'h00);
      issue(7'h50, 1'b1, 8'h34, 16'h0000, 1, 1'b0, 8'h11, 8'h22);
      issue(7'h50, 1'b0, 8'h77, 16'h2468, 0, 1'b0, 8'h00, 8'h00);
      issue(7'h21, 1'b0, 8'h9C, 16'h0F0F, -1, 1'b1, 8'h00, 8'h00);

      // Reset in the middle of the data[15:8] byte.
      nack_at = -1;
      model(7'h3C, 1'b0, 8'h44, 16'hBEEF, -1);
      device_addr = 7'h3C; rw = 1'b0; reg_addr = 8'h44; i2c_data = 16'hBEEF;
      i2c_enable = 1'b1;
      @(negedge clk);
      i2c_enable = 1'b0;
      n = 0;
      while (!(rx_cnt == 2 && bitpos >= 3) && n < BOUND) begin @(negedge clk); n++; end
      if (n >= BOUND) fail("rst_wait", "data byte never reached");
      #2 rst_n = 1'b0;
      #1;
      chk("async_scl", longint'(scl), 1);
      chk("async_sda_oe", longint'(sda_oe), 0);
      chk("async_busy", longint'(busy), 0);
      mon_en = 1'b0;
      bus_q.delete();
      exp_q.delete();
      exp_rd = '0;
      repeat (3) @(negedge clk);
      chk("async_rd_data", longint'(rd_data), 0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      issue(7'h3C, 1'b0, 8'h44, 16'hBEEF, -1, 1'b0, 8'h00, 8'h00);

      for (int i = 0; i < 30; i++) begin
`ifdef I2C_MASTER_READ_EN
         r = 1'($urandom_range(0, 1));
`else
         r = ($urandom_range(0, 4) == 0);
`endif
         nk = ($urandom_range(0, 9) < 6) ? -1 : int'($urandom_range(0, 3));
         issue(7'($urandom), r, 8'($urandom), 16'($urandom), nk,
               ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom));
      end

      repeat (10) @(negedge clk);
      chk("bus_q_left", longint'(bus_q.size()), 0);
      chk("exp_q_left", longint'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
